mips_mc_controller: RTL and testbench

- Moore finite-state machine (FSM) control unit for a multicycle MIPS datapath with a shared instruction/data memory.
- Sequences fetch, decode, execute, memory and writeback for R-type, lw, sw and beq.
- Arbitrates a maskable interrupt (INT, gated by INTD) and a non-maskable interrupt (NMI) at instruction boundaries.
- Drives every datapath mux and enable; the datapath computes Zero and owns the PC, IR, ALUOut and EPC registers.

---
 rtl/mips_ctrl_pkg.sv | 33 +++
 rtl/mips_alu_funct_decode.sv | 23 ++
 rtl/mips_mc_controller.sv | 125 ++++++++++++
 tb/tb_mips_mc_controller.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS controller: FSM states, opcodes,
// R-type funct codes and ALU operation codes.
package mips_ctrl_pkg;

    typedef enum logic [3:0] {
        FETCH,
        DECODE,
        MEMADR,
        MEMRD,
        MEMWB,
        MEMWR,
        EXEC,
        ALUWB,
        BRANCH,
        INTACK
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;

    localparam logic [5:0] F_ADD = 6'b100000;
    localparam logic [5:0] F_SUB = 6'b100010;
    localparam logic [5:0] F_AND = 6'b100100;
    localparam logic [5:0] F_OR  = 6'b100101;

    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_SUB = 2'b01;
    localparam logic [1:0] ALU_AND = 2'b10;
    localparam logic [1:0] ALU_OR  = 2'b11;

endpackage

// File: rtl/mips_alu_funct_decode.sv
// Maps an R-type funct field to an ALU operation; valid is low for
// unsupported funct codes so DECODE can treat them as no-ops.
module mips_alu_funct_decode
    import mips_ctrl_pkg::*;
(
    input  logic [5:0] funct,
    output logic [1:0] alu_ctrl,
    output logic       valid
);

    always_comb begin
        alu_ctrl = ALU_ADD;
        valid    = 1'b1;
        case (funct)
            F_ADD:   alu_ctrl = ALU_ADD;
            F_SUB:   alu_ctrl = ALU_SUB;
            F_AND:   alu_ctrl = ALU_AND;
            F_OR:    alu_ctrl = ALU_OR;
            default: valid    = 1'b0;
        endcase
    end

endmodule

// File: rtl/mips_mc_controller.sv
// Moore control FSM for a multicycle MIPS datapath with interrupt acknowledge
// at instruction boundaries; outputs are a combinational decode of state.
module mips_mc_controller
    import mips_ctrl_pkg::*;
(
    input  logic       Clk,
    input  logic       Rst_n,
    input  logic [5:0] Op,
    input  logic [5:0] funct,
    input  logic       INT,
    input  logic       NMI,
    input  logic       INTD,
    output logic       isBranch,
    output logic       PCWrite,
    output logic       lorD,
    output logic       MemWrite,
    output logic       MemtoReg,
    output logic       IRWrite,
    output logic       INA,
    output logic [1:0] aluControl,
    output logic [1:0] ALUSrcB,
    output logic       PCSource,
    output logic       ALUSrcA,
    output logic       RegWrite,
    output logic       RegDst,
    output logic       isInterrupted
);

    state_t     state;
    logic       irq_pending;
    logic [1:0] funct_alu;
    logic       funct_ok;

    assign irq_pending = NMI | (INT & ~INTD);

    mips_alu_funct_decode u_funct_decode (
        .funct    (funct),
        .alu_ctrl (funct_alu),
        .valid    (funct_ok)
    );

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state <= FETCH;
        end else begin
            case (state)
                FETCH:   state <= irq_pending ? INTACK : DECODE;
                DECODE: begin
                    if (Op == OP_RTYPE && funct_ok)       state <= EXEC;
                    else if (Op == OP_LW || Op == OP_SW)  state <= MEMADR;
                    else if (Op == OP_BEQ)                state <= BRANCH;
                    else                                  state <= FETCH;
                end
                MEMADR:  state <= (Op == OP_SW) ? MEMWR : ((Op == OP_LW) ? MEMRD : FETCH);
                MEMRD:   state <= MEMWB;
                EXEC:    state <= ALUWB;
                default: state <= FETCH;
            endcase
        end
    end

    // A pending interrupt blanks FETCH so neither PC nor IR moves before INTACK.
    always_comb begin
        isBranch      = 1'b0;
        PCWrite       = 1'b0;
        lorD          = 1'b0;
        MemWrite      = 1'b0;
        MemtoReg      = 1'b0;
        IRWrite       = 1'b0;
        INA           = 1'b0;
        aluControl    = ALU_ADD;
        ALUSrcB       = 2'b00;
        PCSource      = 1'b0;
        ALUSrcA       = 1'b0;
        RegWrite      = 1'b0;
        RegDst        = 1'b0;
        isInterrupted = 1'b0;
        if (Rst_n) begin
            case (state)
                FETCH: begin
                    if (!irq_pending) begin
                        IRWrite = 1'b1;
                        PCWrite = 1'b1;
                        ALUSrcB = 2'b01;
                    end
                end
                DECODE:  ALUSrcB = 2'b11;
                MEMADR: begin
                    ALUSrcA = 1'b1;
                    ALUSrcB = 2'b10;
                end
                MEMRD:   lorD = 1'b1;
                MEMWB: begin
                    RegWrite = 1'b1;
                    MemtoReg = 1'b1;
                end
                MEMWR: begin
                    lorD     = 1'b1;
                    MemWrite = 1'b1;
                end
                EXEC: begin
                    ALUSrcA    = 1'b1;
                    aluControl = funct_alu;
                end
                ALUWB: begin
                    RegWrite = 1'b1;
                    RegDst   = 1'b1;
                end
                BRANCH: begin
                    ALUSrcA    = 1'b1;
                    aluControl = ALU_SUB;
                    PCSource   = 1'b1;
                    isBranch   = 1'b1;
                end
                INTACK: begin
                    INA           = 1'b1;
                    isInterrupted = 1'b1;
                    PCWrite       = 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mips_mc_controller.sv
// Bench for mips_mc_controller: per-instruction output-sequence model checked
// every cycle, plus directed literal checks on the specified scenarios.
module tb_mips_mc_controller;

    typedef struct packed {
        logic       br;
        logic       pcw;
        logic       iord;
        logic       memw;
        logic       m2r;
        logic       irw;
        logic       ina;
        logic [1:0] alu;
        logic [1:0] srcb;
        logic       pcsrc;
        logic       srca;
        logic       regw;
        logic       regdst;
        logic       intr;
    } ov_t;

    logic       Clk = 1'b0;
    logic       Rst_n = 1'b0;
    logic [5:0] Op = 6'b000000;
    logic [5:0] funct = 6'b100000;
    logic       INT = 1'b0;
    logic       NMI = 1'b0;
    logic       INTD = 1'b0;
    logic       isBranch, PCWrite, lorD, MemWrite, MemtoReg, IRWrite, INA;
    logic [1:0] aluControl, ALUSrcB;
    logic       PCSource, ALUSrcA, RegWrite, RegDst, isInterrupted;

    int  n_checks = 0;
    int  n_errors = 0;
    ov_t exp_q[$];
    ov_t hist[$];
    ov_t dut_v;

    mips_mc_controller dut (
        .Clk(Clk), .Rst_n(Rst_n), .Op(Op), .funct(funct),
        .INT(INT), .NMI(NMI), .INTD(INTD),
        .isBranch(isBranch), .PCWrite(PCWrite), .lorD(lorD),
        .MemWrite(MemWrite), .MemtoReg(MemtoReg), .IRWrite(IRWrite),
        .INA(INA), .aluControl(aluControl), .ALUSrcB(ALUSrcB),
        .PCSource(PCSource), .ALUSrcA(ALUSrcA), .RegWrite(RegWrite),
        .RegDst(RegDst), .isInterrupted(isInterrupted)
    );

    always #5 Clk = ~Clk;

    assign dut_v = {isBranch, PCWrite, lorD, MemWrite, MemtoReg, IRWrite, INA,
                    aluControl, ALUSrcB, PCSource, ALUSrcA, RegWrite, RegDst,
                    isInterrupted};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ALU op an R-type funct must select; -1 marks an unsupported funct.
    function automatic int alu_of(input logic [5:0] f);
        case (f)
            6'b100000: return 0;
            6'b100010: return 1;
            6'b100100: return 2;
            6'b100101: return 3;
            default:   return -1;
        endcase
    endfunction

    // Expected per-cycle outputs of one whole instruction (or interrupt) from FETCH.
    task automatic build(input logic [5:0] op, input logic [5:0] f, input logic irq);
        ov_t v;
        if (irq) begin
            exp_q.push_back('0);
            v = '0; v.ina = 1'b1; v.intr = 1'b1; v.pcw = 1'b1;
            exp_q.push_back(v);
            return;
        end
        v = '0; v.irw = 1'b1; v.pcw = 1'b1; v.srcb = 2'b01;
        exp_q.push_back(v);
        v = '0; v.srcb = 2'b11;
        exp_q.push_back(v);
        if (op == 6'b000000 && alu_of(f) >= 0) begin
            v = '0; v.srca = 1'b1; v.alu = 2'(alu_of(f));
            exp_q.push_back(v);
            v = '0; v.regw = 1'b1; v.regdst = 1'b1;
            exp_q.push_back(v);
        end else if (op == 6'b100011 || op == 6'b101011) begin
            v = '0; v.srca = 1'b1; v.srcb = 2'b10;
            exp_q.push_back(v);
            v = '0; v.iord = 1'b1; v.memw = (op == 6'b101011);
            exp_q.push_back(v);
            if (op == 6'b100011) begin
                v = '0; v.regw = 1'b1; v.m2r = 1'b1;
                exp_q.push_back(v);
            end
        end else if (op == 6'b000100) begin
            v = '0; v.srca = 1'b1; v.alu = 2'b01; v.pcsrc = 1'b1; v.br = 1'b1;
            exp_q.push_back(v);
        end
    endtask

    always @(negedge Clk) begin
        if (!Rst_n) begin
            exp_q.delete();
            chk("model_reset", 32'(dut_v), 32'h0);
        end else begin
            if (exp_q.size() == 0)
                build(Op, funct, NMI | (INT & ~INTD));
            chk("model_cycle", 32'(dut_v), 32'(exp_q.pop_front()));
        end
    end

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    // Records n cycles plus the first cycle of the following instruction.
    task automatic capture(input int n);
        hist.delete();
        for (int i = 0; i < n; i++) begin
            hist.push_back(dut_v);
            step();
        end
        hist.push_back(dut_v);
    endtask

    function automatic int gap();
        for (int i = 1; i < hist.size(); i++)
            if (hist[i].irw) return i;
        return -1;
    endfunction

    function automatic int count_irw();
        int c = 0;
        foreach (hist[i]) c += int'(hist[i].irw);
        return c;
    endfunction

    function automatic int count_ina();
        int c = 0;
        foreach (hist[i]) c += int'(hist[i].ina);
        return c;
    endfunction

    function automatic int count_wr();
        int c = 0;
        foreach (hist[i]) c += int'(hist[i].regw) + int'(hist[i].memw);
        return c;
    endfunction

    initial begin
        repeat (3) step();
        chk("reset_outputs", 32'(dut_v), 32'h0);

        // R-type add, 5 back-to-back instructions
        Rst_n = 1'b1;
        #1;
        capture(20);
        chk("rtype_irw_pulses", count_irw(), 6);
        chk("rtype_exec_alu", 32'(hist[2].alu), 32'h0);
        chk("rtype_exec_srca", 32'(hist[2].srca), 32'h1);
        chk("rtype_wb_regw", 32'(hist[3].regw), 32'h1);
        chk("rtype_wb_regdst", 32'(hist[3].regdst), 32'h1);

        Op = 6'b100011;
        capture(5);
        chk("lw_memrd_lord", 32'(hist[3].iord), 32'h1);
        chk("lw_memwb_regw", 32'(hist[4].regw), 32'h1);
        chk("lw_memwb_m2r", 32'(hist[4].m2r), 32'h1);
        chk("lw_irw_gap", gap(), 5);

        Op = 6'b101011;
        capture(4);
        chk("sw_memwrite", 32'(hist[3].memw), 32'h1);
        chk("sw_lord", 32'(hist[3].iord), 32'h1);
        chk("sw_no_regwrite", 32'(hist[0].regw | hist[1].regw | hist[2].regw | hist[3].regw), 32'h0);
        chk("sw_irw_gap", gap(), 4);

        Op = 6'b000100;
        capture(3);
        chk("beq_isbranch", 32'(hist[2].br), 32'h1);
        chk("beq_pcsource", 32'(hist[2].pcsrc), 32'h1);
        chk("beq_alu_sub", 32'(hist[2].alu), 32'h1);
        chk("beq_next_fetch", 32'(hist[3].irw), 32'h1);

        // masked INT
        Op = 6'b000000; funct = 6'b100010;
        INT = 1'b1; INTD = 1'b1;
        capture(8);
        chk("masked_int_no_ina", count_ina(), 0);
        chk("masked_int_gap", gap(), 4);

        // unmasked INT taken at the boundary
        INTD = 1'b0;
        #1;
        chk("int_fetch_suppressed", 32'(IRWrite), 32'h0);
        step();
        chk("int_ina", 32'(INA), 32'h1);
        chk("int_isinterrupted", 32'(isInterrupted), 32'h1);
        chk("int_ack_no_irw", 32'(IRWrite), 32'h0);
        INT = 1'b0;
        step();
        chk("int_refetch_irw", 32'(IRWrite), 32'h1);
        chk("int_ina_one_cycle", 32'(INA), 32'h0);
        capture(4);
        chk("int_after_gap", gap(), 4);

        // NMI ignores INTD
        INTD = 1'b1; NMI = 1'b1;
        #1;
        chk("nmi_fetch_suppressed", 32'(IRWrite), 32'h0);
        step();
        chk("nmi_ina", 32'(INA), 32'h1);
        NMI = 1'b0;
        step();
        chk("nmi_refetch_irw", 32'(IRWrite), 32'h1);
        capture(4);
        chk("nmi_after_gap", gap(), 4);

        // reset in the middle of lw
        Op = 6'b100011;
        repeat (3) step();
        chk("memrd_lord_before_reset", 32'(lorD), 32'h1);
        #1 Rst_n = 1'b0;
        #1;
        chk("reset_async_outputs", 32'(dut_v), 32'h0);
        Op = 6'b111111;
        step();
        Rst_n = 1'b1;
        #1;
        chk("post_reset_irw", 32'(IRWrite), 32'h1);
        chk("post_reset_pcw", 32'(PCWrite), 32'h1);

        // undefined opcode and unsupported funct are 2-cycle no-ops
        capture(2);
        chk("undef_op_gap", gap(), 2);
        chk("undef_op_no_write", count_wr(), 0);
        Op = 6'b000000; funct = 6'b101010;
        capture(2);
        chk("undef_funct_gap", gap(), 2);
        chk("undef_funct_no_write", count_wr(), 0);

        funct = 6'b100101;
        capture(4);
        chk("rtype_or_gap", gap(), 4);
        chk("rtype_or_alu", 32'(hist[2].alu), 32'h3);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
